// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Shares the single-port simulation RAM between the CPU
//             instruction-fetch requester and the data-memory requester.
//             Data requests win by default. A fetch that has been denied
//             STARVE_LIMIT consecutive cycles wins the next conflict.
//             A branch flush blocks new fetch grants and drops the response
//             of a fetch that is already in flight.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, reset_n          : clock (rising edge), async active-low reset
//    if_req_valid/ready      : fetch request handshake (ready = grant)
//    if_addr, if_flush       : fetch address, branch redirect
//    if_resp_valid, if_rdata : fetch response, one cycle after grant
//    dm_req_valid/ready      : data request handshake (ready = grant)
//    dm_we, dm_addr, dm_wdata: data write enable, address and write data
//    dm_resp_valid, dm_rdata : data response (rdata is 0 for writes)
//    ram_ce, ram_wen         : RAM chip enable and write enable
//    ram_raddr, ram_waddr    : RAM read and write addresses
//    ram_wdata, ram_rdata    : RAM write data, registered read data
//  Optional (macro RAM_ARB_PERF_EN defined):
//    perf_if_grants, perf_dm_grants, perf_conflicts, perf_flush_kills
//    32-bit saturating event counters
// ============================================================================
module ram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req_valid,
  output logic              dm_req_ready,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_resp_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              ram_ce,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_conflicts,
  output logic [31:0]       perf_flush_kills
`endif
);

  // State encodes the transaction issued in the previous cycle.
  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_rd_if = 2'd1;
  localparam logic [1:0] c_rd_dm = 2'd2;
  localparam logic [1:0] c_wr_dm = 2'd3;

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [3:0] r_starve_cnt;
  logic       r_flush_kill;

  logic w_if_compete;
  logic w_dm_compete;
  logic w_starved;
  logic w_if_grant;
  logic w_dm_grant;
  logic w_if_killed;

  // Grants are qualified with reset_n so every output reads 0 while reset
  // is asserted, even if requesters keep their valids high.
  assign w_if_compete = reset_n & if_req_valid & ~if_flush;
  assign w_dm_compete = reset_n & dm_req_valid;
  assign w_starved    = (r_starve_cnt >= c_starve_limit);
  assign w_if_grant   = w_if_compete & (~w_dm_compete | w_starved);
  assign w_dm_grant   = w_dm_compete & ~w_if_grant;

  // A fetch response is dropped by a flush in its response cycle, or by a
  // flush registered from the issue cycle (a second guard; the grant rule
  // already keeps a flushed cycle from issuing a fetch).
  assign w_if_killed  = (r_state == c_rd_if) & (if_flush | r_flush_kill);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: next state is the type of this cycle's grant
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = c_idle;
    if (w_if_grant) begin
      w_next_state = c_rd_if;
    end else if (w_dm_grant) begin
      w_next_state = dm_we ? c_wr_dm : c_rd_dm;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: issue side from the grant, response side from the state
  // --------------------------------------------------------------------------
  always_comb begin
    if_req_ready  = w_if_grant;
    dm_req_ready  = w_dm_grant;
    ram_ce        = w_if_grant | w_dm_grant;
    ram_wen       = 1'b0;
    ram_raddr     = '0;
    ram_waddr     = '0;
    ram_wdata     = '0;
    if_resp_valid = 1'b0;
    if_rdata      = '0;
    dm_resp_valid = 1'b0;
    dm_rdata      = '0;

    if (w_if_grant) begin
      ram_raddr = if_addr;
    end else if (w_dm_grant) begin
      if (dm_we) begin
        ram_wen   = 1'b1;
        ram_waddr = dm_addr;
        ram_wdata = dm_wdata;
      end else begin
        ram_raddr = dm_addr;
      end
    end

    case (r_state)
      c_rd_if: begin
        if (!w_if_killed) begin
          if_resp_valid = 1'b1;
          if_rdata      = ram_rdata;
        end
      end
      c_rd_dm: begin
        dm_resp_valid = 1'b1;
        dm_rdata      = ram_rdata;
      end
      c_wr_dm: begin
        dm_resp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Starvation counter: counts consecutive lost conflicts, saturates at 15
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
      r_flush_kill <= 1'b0;
    end else begin
      r_flush_kill <= if_flush;
      if (w_if_compete && !w_if_grant) begin
        if (r_starve_cnt != 4'hF) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

`ifdef RAM_ARB_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic w_conflict;
  assign w_conflict = w_if_compete & w_dm_compete;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_if_grants   <= '0;
      perf_dm_grants   <= '0;
      perf_conflicts   <= '0;
      perf_flush_kills <= '0;
    end else begin
      if (w_if_grant && (perf_if_grants != 32'hFFFF_FFFF)) begin
        perf_if_grants <= perf_if_grants + 32'd1;
      end
      if (w_dm_grant && (perf_dm_grants != 32'hFFFF_FFFF)) begin
        perf_dm_grants <= perf_dm_grants + 32'd1;
      end
      if (w_conflict && (perf_conflicts != 32'hFFFF_FFFF)) begin
        perf_conflicts <= perf_conflicts + 32'd1;
      end
      if (w_if_killed && (perf_flush_kills != 32'hFFFF_FFFF)) begin
        perf_flush_kills <= perf_flush_kills + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port simulation RAM (ce/wen, separate raddr/waddr, 32-bit data, 1-cycle registered read) between the CPU instruction-fetch requester and the data-memory requester.
- Sits between cpu_top and the RAM model inside SimTop; replaces direct cpu-to-RAM wiring.
- Arbitration is data-first with an anti-starvation counter for fetch.
- Branch flush suppresses stale fetch responses.

Parameters:
ADDR_W, 32, address width of both requesters and RAM
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive denied cycles after which a waiting fetch wins arbitration (1..15)

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
if_req_valid  input  1  fetch read request
if_req_ready  output  1  fetch request accepted this cycle (combinational grant)
if_addr  input  ADDR_W  fetch address
if_flush  input  1  branch redirect; kills pending/outstanding fetch
if_resp_valid  output  1  fetch data valid
if_rdata  output  DATA_W  fetch data
dm_req_valid  input  1  data request
dm_req_ready  output  1  data request accepted this cycle
dm_we  input  1  1 = write, 0 = read
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  write data
dm_resp_valid  output  1  data read data valid / write done
dm_rdata  output  DATA_W  data read result (0 for writes)
ram_ce  output  1  RAM chip enable
ram_wen  output  1  RAM write enable
ram_raddr  output  ADDR_W  RAM read address
ram_waddr  output  ADDR_W  RAM write address
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  RAM read data, valid 1 cycle after read issue

Behaviour:
- Reset (reset_n low, async): state IDLE, starve counter 0, perf counters 0; all outputs 0.
- FSM states: IDLE, RD_IF, RD_DM, WR_DM. State records the transaction issued in the previous cycle.
- Exactly one grant per cycle, at most. Grant is combinational from valid inputs and the starve counter.
- A new grant is allowed in every state, so back-to-back issue gives full throughput. Next state is the type of the new grant, else IDLE.
- Grant rule:
  - Fetch competes only when if_req_valid=1 and if_flush=0.
  - If both compete, data wins unless starve counter >= STARVE_LIMIT, in which case fetch wins.
  - A lone competitor always wins.
- Starve counter:
  - Increments (saturating at 15) each cycle fetch competes and loses.
  - Clears on a fetch grant, and clears when fetch does not compete.
- Issue cycle N:
  - ram_ce=1.
  - Read: ram_raddr=addr, ram_wen=0.
  - Data write: ram_wen=1, ram_waddr=dm_addr, ram_wdata=dm_wdata.
  - With no grant: ram_ce=0, ram_wen=0, addresses/data 0.
- Response cycle N+1:
  - RD_IF: if_resp_valid=1, if_rdata=ram_rdata, unless if_flush was high in cycle N+1 or the flush-kill flag is set.
  - RD_DM: dm_resp_valid=1, dm_rdata=ram_rdata.
  - WR_DM: dm_resp_valid=1, dm_rdata=0.
  - Responses are combinational from state and ram_rdata. No backpressure on responses; requesters must accept.
- Flush:
  - if_flush in cycle N blocks a fetch grant in cycle N.
  - if_flush in the response cycle of RD_IF forces if_resp_valid=0.
  - Data traffic is never affected by flush.
- if_req_ready and dm_req_ready are never both 1 in the same cycle.
- Requester holds valid/address stable until ready.
- Reset asserted mid-transaction: the outstanding response is dropped and no response pulse appears after reset release.

Optional Feature:
RAM_ARB_PERF_EN:
- Defined: adds 32-bit counters perf_if_grants, perf_dm_grants, perf_conflicts (cycles where both competed) and perf_flush_kills (suppressed fetch responses).
- Counters saturate at 0xFFFFFFFF and are exposed as extra output ports of the same names.
- Not defined: these ports and registers do not exist; the arbiter's core behaviour is identical either way.

Test Plan:
- Lone fetch: if_addr=0x1c000000, RAM word 0x02800413 -> ram_ce=1, ram_raddr=0x1c000000 in cycle N; if_resp_valid=1, if_rdata=0x02800413 in N+1.
- Data write then read: dm_we=1 @0x1c000100 wdata=0xdeadbeef, next cycle dm_we=0 same addr -> ram_wen=1 then 0; dm_resp_valid both cycles; read returns 0xdeadbeef.
- Conflict: both valid continuously, data always requesting, STARVE_LIMIT=4 -> data granted 4 cycles, fetch granted on cycle 5, pattern repeats; never both ready=1.
- Flush: fetch granted cycle N, if_flush=1 in N+1 -> if_resp_valid=0 in N+1; if_flush with if_req_valid in same cycle -> if_req_ready=0, no RAM read.
- Async reset: reset_n low mid RD_DM -> all outputs 0 immediately; after release, no dm_resp_valid until a new grant.
- RAM_ARB_PERF_EN: 3 fetch grants, 2 data grants, 1 conflict, 1 flush kill -> counters read 3/2/1/1.
